// File: rtl/smu_bitstream_loader_if.sv
// smu_bitstream_loader_if: host word valid/ready channel into the bitstream loader
interface smu_bitstream_loader_if #(parameter int WORD_W = 32);
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  modport master (output s_valid, s_data, input s_ready);
  modport slave  (input s_valid, s_data, output s_ready);
endinterface

// File: rtl/smu_bitstream_loader.sv
// smu_bitstream_loader: checks a framed config load from the host and streams its payload LSB-first to the SMU
module smu_bitstream_loader #(
  parameter int          WORD_W   = 32,
  parameter int          CFG_SIZE = 120,
  parameter logic [15:0] MAGIC    = 16'hA5C3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  smu_bitstream_loader_if.slave         s,
  input  logic                          Clear,
  output logic                          BitStreamSerialIn,
  output logic                          BitStreamValid,
  output logic                          LoadDone,
  output logic                          LoadErr,
  output logic [1:0]                    ErrCode
);
  localparam int NUM_WORDS = (CFG_SIZE + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CFG_SIZE - (NUM_WORDS - 1) * WORD_W;
  localparam int WC_W      = $clog2(NUM_WORDS + 1);
  localparam int BC_W      = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CSUM, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic              ready_q, ready_d;
  logic              bsv_q, bsv_d;
  logic              bsi_q, bsi_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              xfer, last;
  logic [BC_W-1:0]   nbits;

  assign s.s_ready         = ready_q;
  assign BitStreamValid    = bsv_q;
  assign BitStreamSerialIn = bsi_q;
  assign LoadDone          = done_q;
  assign LoadErr           = err_q;
  assign ErrCode           = code_q;

  assign xfer  = s.s_valid && ready_q;
  assign last  = wcnt_q == WC_W'(NUM_WORDS);
  assign nbits = last ? BC_W'(LAST_BITS) : BC_W'(WORD_W);

  // Next-state, datapath and registered-output values; the first payload bit is emitted on the load edge
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    code_d  = code_q;
    bsv_d   = 1'b0;
    bsi_d   = 1'b0;
    if (Clear) begin
      state_d = IDLE;
      wcnt_d  = '0;
      bcnt_d  = '0;
      acc_d   = '0;
      code_d  = 2'b00;
    end else begin
      case (state_q)
        IDLE: if (xfer) begin
          state_d = (s.s_data[WORD_W-1 -: 16] == MAGIC && s.s_data[15:0] == 16'(NUM_WORDS)) ? LOAD : ERR;
          code_d  = (state_d == ERR) ? 2'b01 : 2'b00;
          wcnt_d  = '0;
          acc_d   = '0;
        end
        LOAD: if (xfer) begin
          state_d = SHIFT;
          sh_d    = s.s_data >> 1;
          bsi_d   = s.s_data[0];
          bsv_d   = 1'b1;
          bcnt_d  = BC_W'(1);
          acc_d   = acc_q ^ s.s_data;
          wcnt_d  = wcnt_q + WC_W'(1);
        end
        SHIFT: if (bcnt_q == nbits) begin
          state_d = last ? CSUM : LOAD;
        end else begin
          bsv_d  = 1'b1;
          bsi_d  = sh_q[0];
          sh_d   = sh_q >> 1;
          bcnt_d = bcnt_q + BC_W'(1);
        end
        CSUM: if (xfer) begin
          state_d = (s.s_data == acc_q) ? DONE : ERR;
          code_d  = (s.s_data == acc_q) ? 2'b00 : 2'b10;
        end
        default: state_d = state_q;
      endcase
    end
    ready_d = state_d inside {IDLE, LOAD, CSUM};
    done_d  = state_d == DONE;
    err_d   = state_d == ERR;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      ready_q <= 1'b0;
      bsv_q   <= 1'b0;
      bsi_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      ready_q <= ready_d;
      bsv_q   <= bsv_d;
      bsi_q   <= bsi_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end
endmodule
